alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational integer ALU instance between NREQ requesters, for example the execute stage and an address-generation/branch-compare path.
- Each requester has a valid/ready request channel. Arbitration is round-robin.
- The granted operands and op drive the ALU combinationally. The result and branch flags are captured into a one-entry response register tagged with the requester ID.
- The response register drains through a valid/ready channel. Throughput is one operation per cycle; latency is one cycle.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU WIDTH.
- NREQ, 2, number of requesters; must be at least 2.
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  NREQ*WIDTH  flattened operand A; requester i uses [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  flattened operand B, same slicing.
- req_op  in  NREQ*$bits(alu_op_t)  flattened alu_op_t per requester.
- alu_a  out  WIDTH  to ALU operand a.
- alu_b  out  WIDTH  to ALU operand b.
- alu_op  out  alu_op_t  to ALU op.
- alu_y  in  WIDTH  ALU result.
- alu_bsr  in  3  ALU compare flags: [2] eq, [1] signed lt, [0] unsigned lt.
- resp_valid  out  1  response register holds a result.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  IDW  index of the requester that issued the result.
- resp_y  out  WIDTH  registered result.
- resp_bsr  out  3  registered compare flags.

Behaviour:
- Reset (asynchronous, rst_n=0): resp_valid=0, resp_id=0, resp_y=0, resp_bsr=0, rr_ptr=0.
- slot_free = !resp_valid || resp_ready (combinational).
- Grant rule: when slot_free, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ. Otherwise there is no grant.
  - req_ready = one-hot grant vector, or all zeros.
  - req_ready may depend combinationally on req_valid and resp_ready.
  - A requester must not make req_valid depend on req_ready.
- ALU drive:
  - With a grant: alu_a/alu_b/alu_op equal the granted requester's slices.
  - Without a grant: alu_a=0, alu_b=0, alu_op=ALU_PASS_RS1.
- Accept edge (grant present):
  - resp_valid<=1.
  - resp_id<=granted index.
  - resp_y<=alu_y.
  - resp_bsr<=alu_bsr.
  - rr_ptr<=(granted index+1) mod NREQ.
- Drain edge without a new accept (resp_valid && resp_ready, no grant): resp_valid<=0. resp_y, resp_bsr and resp_id hold their values.
- Simultaneous drain and accept: the new result replaces the old one in the same edge and resp_valid stays 1. Back-to-back throughput is one per cycle.
- Backpressure (resp_valid=1, resp_ready=0):
  - All req_ready=0.
  - Response register and rr_ptr hold.
  - Requesters must keep req_valid and their operands stable until accepted.
- rr_ptr changes only on an accept. An idle cycle does not advance it.
- Fairness: a continuously valid requester is granted within NREQ accepts.
- Latency: accept at edge N gives resp_valid=1 after edge N.
- Reset mid-operation: a pending response is discarded and the pointer returns to 0. No partial state survives.
- No arithmetic is done in this block. The results are bit-exact ALU outputs.

Decomposition:
- alu_op_t and its encodings stay in the shared datatypes package.
- Add to that package:
  - BSR_EQ=2, BSR_LT=1, BSR_LTU=0 index constants.
  - alu_req_t struct {a, b, op} for future unflattened use.
- One natural sub-module: rr_arbiter #(N) (req, ptr -> one-hot grant, grant index), reusable for other shared resources.
- The ALU is instantiated outside this block.
- The bench instantiates the real alu alongside alu_arbiter.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 with req_valid=2'b11 after a prior accept.
  - Response: resp_valid=0, resp_y=0, req_ready=0 during reset. The first grant after release goes to requester 0.
- Single requester:
  - Stimulus: req0 a=5, b=7, op=ALU_ADD, resp_ready=1.
  - Response: req_ready=2'b01 in the same cycle. Next cycle resp_valid=1, resp_id=0, resp_y=12, resp_bsr=3'b011.
- Round-robin:
  - Stimulus: both requesters valid for 4 cycles with resp_ready=1. req0 op=ALU_SUB a=3 b=3; req1 op=ALU_SLT a=32'hFFFFFFFF b=1.
  - Response: grants alternate 0,1,0,1. req0 results resp_y=0, bsr=3'b100. req1 results resp_y=1, bsr=3'b010.
- Backpressure:
  - Stimulus: resp_ready=0 for 3 cycles after an accept, with req1 valid.
  - Response: req_ready=0 and resp_y held for those cycles. When resp_ready=1, the drain and the req1 accept occur on the same edge.
- Idle pointer:
  - Stimulus: req1 accepted, then 5 idle cycles, then both requesters valid.
  - Response: requester 0 is granted first (rr_ptr=0 held through idle). alu_op=ALU_PASS_RS1 and alu_a=0 while idle.
- Shift/SRA via arbiter:
  - Stimulus: req1 op=ALU_SRA a=32'h80000000 b=4.
  - Response: resp_y=32'hF8000000, resp_id=1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared datatypes for the integer ALU and its arbitrated front end.
// Provides the ALU op encoding, compare-flag bit indices, an unflattened
// request payload and a helper for sizing index fields.
package alu_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  // ALU operation encoding (contiguous from zero)
  typedef enum logic [3:0] {
    ALU_ADD      = 4'd0,
    ALU_SUB      = 4'd1,
    ALU_SLL      = 4'd2,
    ALU_SLT      = 4'd3,
    ALU_SLTU     = 4'd4,
    ALU_XOR      = 4'd5,
    ALU_SRL      = 4'd6,
    ALU_SRA      = 4'd7,
    ALU_OR       = 4'd8,
    ALU_AND      = 4'd9,
    ALU_PASS_RS1 = 4'd10,
    ALU_PASS_RS2 = 4'd11
  } alu_op_t;

  localparam int unsigned ALU_OPW  = $bits(alu_op_t);
  localparam int unsigned ALU_NOPS = 12;

  // Bit positions inside the 3-bit compare flag vector
  localparam int unsigned BSR_W   = 3;
  localparam int unsigned BSR_EQ  = 2;
  localparam int unsigned BSR_LT  = 1;
  localparam int unsigned BSR_LTU = 0;

  // One requester's operands and op as a single payload
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_t         op;
  } alu_req_t;

  // Width of an index into n items, never below one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared by several requesters.
// Ports: a, b   operands
//        op     operation (alu_op_t)
//        y      result
//        bsr    compare flags {eq, signed lt, unsigned lt} of a vs b
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y,
  output logic [BSR_W-1:0] bsr
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  logic           lt;
  logic           ltu;

  assign shamt = b[SHW-1:0];
  assign lt    = $signed(a) < $signed(b);
  assign ltu   = a < b;

  // Compare flags are produced for every op so branches can use any slot
  always_comb begin
    bsr          = '0;
    bsr[BSR_EQ]  = (a == b);
    bsr[BSR_LT]  = lt;
    bsr[BSR_LTU] = ltu;
  end

  // Result select
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:      y = a + b;
      ALU_SUB:      y = a - b;
      ALU_SLL:      y = a << shamt;
      ALU_SLT:      y = WIDTH'(lt);
      ALU_SLTU:     y = WIDTH'(ltu);
      ALU_XOR:      y = a ^ b;
      ALU_SRL:      y = a >> shamt;
      ALU_SRA:      y = WIDTH'($signed(a) >>> shamt);
      ALU_OR:       y = a | b;
      ALU_AND:      y = a & b;
      ALU_PASS_RS1: y = a;
      ALU_PASS_RS2: y = b;
      default:      y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin grant logic, reusable for any shared resource.
// Ports: req          request vector
//        ptr          index with highest priority this cycle
//        grant_c      one-hot grant (all zeros when nothing requests)
//        grant_idx_c  index of the granted requester
//        grant_vld_c  a grant is present
module rr_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] grant_idx_c,
  output logic          grant_vld_c
);

  // Scan ptr, ptr+1, ... wrapping at N; first requester found wins
  always_comb begin
    int unsigned j;
    j           = 0;
    grant_c     = '0;
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      if (!grant_vld_c && req[j]) begin
        grant_c[j]  = 1'b1;
        grant_idx_c = IW'(j);
        grant_vld_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NREQ requesters.
// Round-robin arbitration over valid/ready request channels; the granted
// operands drive the ALU and its result is captured into a one-entry
// response register tagged with the requester index.
// Ports: clk, rst_n                       clock, async active-low reset
//        req_valid/req_ready              per-requester handshake
//        req_a/req_b/req_op               flattened per-requester payloads
//        alu_a/alu_b/alu_op               drive to the ALU (combinational)
//        alu_y/alu_bsr                    ALU result and compare flags
//        resp_valid/resp_ready            response handshake
//        resp_id/resp_y/resp_bsr          registered response payload
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*ALU_OPW-1:0] req_op,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output alu_op_t                 alu_op,
  input  logic [WIDTH-1:0]        alu_y,
  input  logic [BSR_W-1:0]        alu_bsr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [WIDTH-1:0]        resp_y,
  output logic [BSR_W-1:0]        resp_bsr
);

  logic            slot_free_c;
  logic [NREQ-1:0] arb_req_c;
  logic [NREQ-1:0] grant_c;
  logic [IDW-1:0]  grant_idx_c;
  logic            grant_vld_c;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_ptr_nxt_c;

  // Response slot can take a new result if empty or draining this cycle;
  // no grant is offered while reset is held
  assign slot_free_c = !resp_valid || resp_ready;
  assign arb_req_c   = req_valid & {NREQ{slot_free_c & rst_n}};

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_rr (
    .req         (arb_req_c),
    .ptr         (rr_ptr),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_vld_c (grant_vld_c)
  );

  assign req_ready = grant_c;

  // Granted payload to the ALU; idle drives a harmless pass of zero
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_PASS_RS1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        alu_a  = req_a[i*WIDTH +: WIDTH];
        alu_b  = req_b[i*WIDTH +: WIDTH];
        alu_op = alu_op_t'(req_op[i*ALU_OPW +: ALU_OPW]);
      end
    end
  end

  // Next priority goes to the requester after the one just served
  assign rr_ptr_nxt_c = (grant_idx_c == IDW'(NREQ - 1)) ? '0 : grant_idx_c + IDW'(1);

  // Response register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_y     <= '0;
      resp_bsr   <= '0;
      rr_ptr     <= '0;
    end else if (grant_vld_c) begin
      resp_valid <= 1'b1;
      resp_id    <= grant_idx_c;
      resp_y     <= alu_y;
      resp_bsr   <= alu_bsr;
      rr_ptr     <= rr_ptr_nxt_c;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter paired with the real alu.
// A queue-free transaction model (pointer, response slot) plus a
// spec-level ALU function predict every cycle's grant and response.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned W    = 32;
  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = $clog2(NREQ);

  logic                    clk;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*W-1:0]       req_a;
  logic [NREQ*W-1:0]       req_b;
  logic [NREQ*ALU_OPW-1:0] req_op;
  logic [W-1:0]            alu_a;
  logic [W-1:0]            alu_b;
  alu_op_t                 alu_op;
  logic [W-1:0]            alu_y;
  logic [2:0]              alu_bsr;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [IDW-1:0]          resp_id;
  logic [W-1:0]            resp_y;
  logic [2:0]              resp_bsr;

  alu #(.WIDTH(W)) u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .op  (alu_op),
    .y   (alu_y),
    .bsr (alu_bsr)
  );

  alu_arbiter #(.WIDTH(W), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_y      (alu_y),
    .alu_bsr    (alu_bsr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .resp_bsr   (resp_bsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit           m_valid;
  int           m_id;
  logic [W-1:0] m_y;
  logic [2:0]   m_bsr;
  int           m_ptr;

  // values observed in the last cycle() call
  logic [NREQ-1:0] obs_ready;
  logic [W-1:0]    obs_a;
  alu_op_t         obs_op;
  int              last_g;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_y(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned sh;
    sh = 32'(b[4:0]);
    case (op)
      ALU_ADD:      return a + b;
      ALU_SUB:      return a - b;
      ALU_SLL:      return a << sh;
      ALU_SLT:      return ($signed(a) < $signed(b)) ? 1 : 0;
      ALU_SLTU:     return (a < b) ? 1 : 0;
      ALU_XOR:      return a ^ b;
      ALU_SRL:      return a >> sh;
      ALU_SRA:      return W'($signed(a) >>> sh);
      ALU_OR:       return a | b;
      ALU_AND:      return a & b;
      ALU_PASS_RS1: return a;
      ALU_PASS_RS2: return b;
      default:      return '0;
    endcase
  endfunction

  function automatic logic [2:0] ref_bsr(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a == b, $signed(a) < $signed(b), a < b};
  endfunction

  function automatic int model_grant();
    int j;
    if (!rst_n) return -1;
    if (m_valid && !resp_ready) return -1;
    for (int k = 0; k < int'(NREQ); k++) begin
      j = (m_ptr + k) % int'(NREQ);
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_y = '0; m_bsr = '0; m_ptr = 0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input alu_op_t op);
    req_valid[i]                = v;
    req_a[i*W +: W]             = a;
    req_b[i*W +: W]             = b;
    req_op[i*ALU_OPW +: ALU_OPW] = op;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  // Entered and left 1 time unit after a rising edge.
  task automatic cycle();
    int              g;
    logic [NREQ-1:0] er;
    logic [W-1:0]    ea, eb;
    alu_op_t         eop;
    #2;
    g   = model_grant();
    er  = '0;
    ea  = '0;
    eb  = '0;
    eop = ALU_PASS_RS1;
    if (g >= 0) begin
      er[g] = 1'b1;
      ea    = req_a[g*W +: W];
      eb    = req_b[g*W +: W];
      eop   = alu_op_t'(req_op[g*ALU_OPW +: ALU_OPW]);
    end
    obs_ready = req_ready;
    obs_a     = alu_a;
    obs_op    = alu_op;
    last_g    = g;
    check("req_ready", req_ready, er);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_op", alu_op, eop);
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1;
      m_id    = g;
      m_y     = ref_y(eop, ea, eb);
      m_bsr   = ref_bsr(ea, eb);
      m_ptr   = (g + 1) % int'(NREQ);
    end else if (m_valid && resp_ready) begin
      m_valid = 0;
    end
    #1;
    check("resp_valid", resp_valid, m_valid);
    check("resp_id", resp_id, m_id);
    check("resp_y", resp_y, m_y);
    check("resp_bsr", resp_bsr, m_bsr);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  bit pend[NREQ];
  int waited[NREQ];

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", resp_valid, 1'b0);
    check("rst_y", resp_y, '0);
    check("rst_id", resp_id, '0);
    check("rst_bsr", resp_bsr, '0);
    rst_n = 1'b1;

    // single requester
    set_req(0, 1, 5, 7, ALU_ADD);
    resp_ready = 1'b1;
    cycle();
    check("single_ready", obs_ready, 2'b01);
    check("single_valid", resp_valid, 1'b1);
    check("single_id", resp_id, 0);
    check("single_y", resp_y, 12);
    check("single_bsr", resp_bsr, 3'b011);
    set_req(0, 0, 0, 0, ALU_ADD);

    // arithmetic shift through requester 1
    set_req(1, 1, 32'h8000_0000, 4, ALU_SRA);
    cycle();
    check("sra_ready", obs_ready, 2'b10);
    check("sra_id", resp_id, 1);
    check("sra_y", resp_y, 32'hF800_0000);
    set_req(1, 0, 0, 0, ALU_ADD);

    // round robin between two continuously valid requesters
    set_req(0, 1, 3, 3, ALU_SUB);
    set_req(1, 1, 32'hFFFF_FFFF, 1, ALU_SLT);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("rr_id", resp_id, k % 2);
      check("rr_y", resp_y, (k % 2 == 0) ? 0 : 1);
      check("rr_bsr", resp_bsr, (k % 2 == 0) ? 3'b100 : 3'b010);
    end
    set_req(0, 0, 0, 0, ALU_ADD);
    set_req(1, 0, 0, 0, ALU_ADD);

    // backpressure holds the slot and blocks grants
    set_req(0, 1, 1, 2, ALU_ADD);
    cycle();
    set_req(0, 0, 0, 0, ALU_ADD);
    set_req(1, 1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_XOR);
    resp_ready = 1'b0;
    repeat (3) begin
      cycle();
      check("bp_ready", obs_ready, 2'b00);
      check("bp_y", resp_y, 3);
      check("bp_valid", resp_valid, 1'b1);
    end
    resp_ready = 1'b1;
    cycle();
    check("bp_release_ready", obs_ready, 2'b10);
    check("bp_release_id", resp_id, 1);
    check("bp_release_y", resp_y, 32'hFF00_FF00);
    set_req(1, 0, 0, 0, ALU_ADD);

    // idle cycles keep the pointer and drive a neutral ALU op
    repeat (5) begin
      cycle();
      check("idle_op", obs_op, ALU_PASS_RS1);
      check("idle_a", obs_a, '0);
    end
    set_req(0, 1, 10, 20, ALU_AND);
    set_req(1, 1, 30, 40, ALU_OR);
    cycle();
    check("idle_first_grant", obs_ready, 2'b01);

    // reset in the middle of traffic
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", resp_valid, 1'b0);
    check("mid_rst_y", resp_y, '0);
    check("mid_rst_ready", req_ready, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    check("post_rst_grant", obs_ready, 2'b01);
    set_req(0, 0, 0, 0, ALU_ADD);
    set_req(1, 0, 0, 0, ALU_ADD);

    // randomized traffic with stable-until-accepted requests
    for (int i = 0; i < int'(NREQ); i++) begin
      pend[i]   = 0;
      waited[i] = 0;
    end
    repeat (2000) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1;
          set_req(i, 1, rnd_operand(), rnd_operand(), alu_op_t'($urandom_range(0, ALU_NOPS - 1)));
        end
        req_valid[i] = pend[i];
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_g >= 0) begin
        check("fairness", waited[last_g] < int'(NREQ), 1'b1);
        waited[last_g] = 0;
        pend[last_g]   = 0;
        for (int i = 0; i < int'(NREQ); i++)
          if (pend[i] && i != last_g) waited[i]++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
